multi_ch_blinker: RTL and testbench

MULTI_CH_BLINKER -- requirements
Module: multi_ch_blinker

---
 rtl/multi_ch_blinker_pkg.sv | 21 ++
 rtl/multi_ch_blinker_if.sv | 29 ++
 rtl/blink_channel.sv | 112 +++++++++++
 rtl/multi_ch_blinker.sv | 47 ++++
 tb/tb_multi_ch_blinker.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/multi_ch_blinker_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encodings and
// the default channel/counter geometry.
package multi_ch_blinker_pkg;

    localparam int MODE_W     = 2;
    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_PULSE  = 2'd3
    } mode_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_ch_blinker_if.sv
// Configuration write channel: valid/ready handshake carrying the target
// channel index and the mode/period/duty to stage into that channel.
interface multi_ch_blinker_if
    import multi_ch_blinker_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    localparam int CH_W = ch_width(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [MODE_W-1:0] cfg_mode;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_duty;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready
    );

endinterface

// File: rtl/blink_channel.sv
// One LED channel: period counter, active and shadow configuration, pending
// flag and the registered led/wrap outputs.
module blink_channel
    import multi_ch_blinker_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              wr_en_i,
    input  logic [MODE_W-1:0] wr_mode_i,
    input  logic [CNT_W-1:0]  wr_period_i,
    input  logic [CNT_W-1:0]  wr_duty_i,
    output logic              pending_o,
    output logic              led_o,
    output logic              wrap_o
);

    mode_e            act_mode_q,   act_mode_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_duty_q,   act_duty_d;
    mode_e            shd_mode_q,   shd_mode_d;
    logic [CNT_W-1:0] shd_period_q, shd_period_d;
    logic [CNT_W-1:0] shd_duty_q,   shd_duty_d;
    logic             pending_q,    pending_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             tog_q,        tog_d;
    logic             led_q,        led_d;
    logic             wrap_q,       wrap_d;

    logic [CNT_W-1:0] eff_period;
    logic             is_wrap;
    logic             commit;
    mode_e            nxt_mode;
    logic [CNT_W-1:0] nxt_duty;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        eff_period = (act_period_q == '0) ? CNT_W'(1) : act_period_q;
        is_wrap    = enable_i && (cnt_q == eff_period - CNT_W'(1));
        // A write accepted on this edge only sets pending_d, so it cannot
        // commit before the following wrap.
        commit     = pending_q && (is_wrap || !enable_i);

        act_mode_d   = commit ? shd_mode_q   : act_mode_q;
        act_period_d = commit ? shd_period_q : act_period_q;
        act_duty_d   = commit ? shd_duty_q   : act_duty_q;
        nxt_mode     = act_mode_d;
        nxt_duty     = act_duty_d;

        shd_mode_d   = wr_en_i ? mode_e'(wr_mode_i) : shd_mode_q;
        shd_period_d = wr_en_i ? wr_period_i        : shd_period_q;
        shd_duty_d   = wr_en_i ? wr_duty_i          : shd_duty_q;

        pending_d = pending_q;
        if (commit)  pending_d = 1'b0;
        if (wr_en_i) pending_d = 1'b1;

        cnt_d  = (!enable_i || is_wrap) ? '0 : cnt_q + CNT_W'(1);
        tog_d  = enable_i && (tog_q ^ is_wrap);
        wrap_d = is_wrap;

        led_d = 1'b0;
        if (enable_i) begin
            case (nxt_mode)
                MODE_TOGGLE: led_d = tog_d;
                MODE_PWM:    led_d = (cnt_d < nxt_duty);
                MODE_PULSE:  led_d = is_wrap;
                default:     led_d = 1'b0;
            endcase
        end
    end

    // Every register is small and control-relevant, so all of them are
    // returned to a known value by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_mode_q   <= MODE_OFF;
            act_period_q <= CNT_W'(1);
            act_duty_q   <= '0;
            shd_mode_q   <= MODE_OFF;
            shd_period_q <= CNT_W'(1);
            shd_duty_q   <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            tog_q        <= 1'b0;
            led_q        <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state, independent of statement order.
            act_mode_q   <= act_mode_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            shd_mode_q   <= shd_mode_d;
            shd_period_q <= shd_period_d;
            shd_duty_q   <= shd_duty_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            tog_q        <= tog_d;
            led_q        <= led_d;
            wrap_q       <= wrap_d;
        end
    end

    assign pending_o = pending_q;
    assign led_o     = led_q;
    assign wrap_o    = wrap_q;

endmodule

// File: rtl/multi_ch_blinker.sv
// NUM_CH independent LED blinkers sharing one configuration write channel;
// the top decodes the handshake and steers each write to its channel.
module multi_ch_blinker
    import multi_ch_blinker_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] enable,
    multi_ch_blinker_if.slave cfg,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] wrap
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;
    logic              ch_valid;

    // Out-of-range indices never see ready, so no write can be lost on them.
    always_comb begin
        ch_valid      = (int'(cfg.cfg_ch) < NUM_CH);
        cfg.cfg_ready = 1'b0;
        if (ch_valid) cfg.cfg_ready = !pending[cfg.cfg_ch];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_ch) == i);

        blink_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .enable_i    (enable[i]),
            .wr_en_i     (wr_en[i]),
            .wr_mode_i   (cfg.cfg_mode),
            .wr_period_i (cfg.cfg_period),
            .wr_duty_i   (cfg.cfg_duty),
            .pending_o   (pending[i]),
            .led_o       (led[i]),
            .wrap_o      (wrap[i])
        );
    end

endmodule

// File: tb/tb_multi_ch_blinker.sv
// Directed bench for multi_ch_blinker: toggle, PWM, shadow/commit handshake,
// pulse with degenerate periods and reset with a write pending.
module tb_multi_ch_blinker;
    import multi_ch_blinker_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] wrap;

    int n_tests = 0;
    int n_fail  = 0;

    multi_ch_blinker_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

    multi_ch_blinker #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .cfg     (cfg_if),
        .led     (led),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge after
    // the accepting rising edge with valid dropped.
    task automatic cfg_write(input int ch, input mode_e mode, input int period, input int duty);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_mode   = mode;
        cfg_if.cfg_period = CNT_W'(period);
        cfg_if.cfg_duty   = CNT_W'(duty);
        #1 check("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Configure a disabled channel: the write stages, the next disabled
    // edge commits it.
    task automatic config_idle(input int ch, input mode_e mode, input int period, input int duty);
        enable[ch] = 1'b0;
        cfg_write(ch, mode, period, duty);
        #1 check("idle_pending", 32'(cfg_if.cfg_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("idle_commit", 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_led, exp_wrap, exp_rdy;

        reset_n           = 1'b0;
        enable            = '0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_mode   = MODE_OFF;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cfg_if.cfg_ch = 2'(ch);
            #1 check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ch0 TOGGLE period 25
        config_idle(0, MODE_TOGGLE, 25, 0);
        enable[0] = 1'b1;
        for (int e = 1; e <= 55; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp_led  = ((e / 25) % 2) == 1;
            exp_wrap = (e % 25) == 0;
            check("tog_led", 32'(led), {28'd0, 3'b000, exp_led});
            check("tog_wrap", 32'(wrap), {28'd0, 3'b000, exp_wrap});
        end
        enable = '0;

        // ch1 PWM period 10 duty 3, then duty 0 and duty 12
        config_idle(1, MODE_PWM, 10, 3);
        enable[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("pwm3_led", 32'(led[1]), 32'((e % 10) < 3));
            check("pwm3_wrap", 32'(wrap[1]), 32'((e % 10) == 0));
        end
        config_idle(1, MODE_PWM, 10, 0);
        enable[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("pwm0_led", 32'(led[1]), 32'd0);
        end
        config_idle(1, MODE_PWM, 10, 12);
        enable[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("pwm12_led", 32'(led[1]), 32'd1);
        end
        enable = '0;

        // ch2 PULSE period 8 running; period 5 written at edge 4 commits at
        // wrap edge 8; period 6 held pending-blocked until then, accepted at 9
        config_idle(2, MODE_PULSE, 8, 0);
        enable[2] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            if (e == 4) begin
                cfg_if.cfg_valid  = 1'b1;
                cfg_if.cfg_ch     = 2'd2;
                cfg_if.cfg_mode   = MODE_PULSE;
                cfg_if.cfg_period = CNT_W'(5);
            end else if (e >= 5 && e <= 9) begin
                cfg_if.cfg_period = CNT_W'(6);
            end else if (e >= 10) begin
                cfg_if.cfg_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            exp_rdy  = !((e >= 4 && e <= 7) || (e >= 9 && e <= 12));
            exp_wrap = (e == 8) || (e == 13) || (e == 19);
            check("shd_ready", 32'(cfg_if.cfg_ready), 32'(exp_rdy));
            check("shd_wrap", 32'(wrap), {28'd0, 1'b0, exp_wrap, 2'b00});
            check("shd_led", 32'(led[2]), 32'(exp_wrap));
        end
        enable = '0;

        // ch3 PULSE period 1 and period 0
        config_idle(3, MODE_PULSE, 1, 0);
        enable[3] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("p1_led", 32'(led), 32'h8);
            check("p1_wrap", 32'(wrap), 32'h8);
        end
        config_idle(3, MODE_PULSE, 0, 0);
        enable[3] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("p0_led", 32'(led), 32'h8);
            check("p0_wrap", 32'(wrap), 32'h8);
        end
        enable = '0;

        // Reset mid-period with a write pending on ch1
        config_idle(1, MODE_PWM, 10, 12);
        enable[1] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("pre_rst_led", 32'(led[1]), 32'd1);
        end
        cfg_write(1, MODE_TOGGLE, 20, 0);
        #1 check("pre_rst_pending", 32'(cfg_if.cfg_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        check("async_rst_wrap", 32'(wrap), 32'd0);
        check("async_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_rst_led", 32'(led), 32'd0);
            check("post_rst_wrap", 32'(wrap), 32'h2);
            check("post_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
